param_delay: RTL and testbench

PARAM_DELAY -- requirements
Module: param_delay

---
 rtl/param_delay_if.sv | 26 ++
 rtl/param_delay.sv | 145 ++++++++++++++
 tb/tb_param_delay.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_delay_if.sv
// rtl/param_delay_if.sv - input/output beat handshake bundle for param_delay
interface param_delay_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/param_delay.sv
// rtl/param_delay.sv - stallable, flushable delay line with run-time selectable depth
module param_delay #(
    parameter  int DATA_W    = 32,
    parameter  int MAX_DEPTH = 16,
    parameter  int DEF_DEPTH = 7,
    localparam int SEL_W     = $clog2(MAX_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    param_delay_if.slave     bus,
    input  logic             stall,
    input  logic             flush,
    input  logic [SEL_W-1:0] depth_sel,
    output logic             busy,
    output logic [SEL_W-1:0] active_depth,
    output logic             depth_err
);
    localparam int NSTG = (MAX_DEPTH > 1) ? MAX_DEPTH - 1 : 1;

    logic [DATA_W-1:0] stg_data_q [NSTG];
    logic [DATA_W-1:0] stg_data_d [NSTG];
    logic [NSTG-1:0]   stg_vld_q;
    logic [NSTG-1:0]   stg_vld_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [SEL_W-1:0]  depth_q;
    logic [SEL_W-1:0]  depth_d;
    logic              err_q;
    logic              err_d;

    logic              advance;
    logic              accept;
    logic [DATA_W-1:0] in_term;
    logic [SEL_W-1:0]  depth_req;
    logic              depth_bad;
    logic              src_vld;
    logic [DATA_W-1:0] src_data;
    logic              busy_w;

    assign bus.in_ready = ~stall;
    assign advance      = ~stall & ~flush;
    assign accept       = bus.in_valid & ~stall & ~flush;
    assign in_term      = accept ? bus.in_data : '0;

    always_comb begin : depth_clamp
        depth_req = depth_sel;
        depth_bad = 1'b0;
        if (depth_sel == '0) begin
            depth_req = SEL_W'(1);
            depth_bad = 1'b1;
        end else if (depth_sel > SEL_W'(MAX_DEPTH)) begin
            depth_req = SEL_W'(MAX_DEPTH);
            depth_bad = 1'b1;
        end
    end

    // Only stages s1..s(D-1) count; deeper stages are held cleared anyway.
    always_comb begin : busy_calc
        busy_w = out_valid_q;
        for (int k = 0; k < NSTG; k++) begin
            if (stg_vld_q[k] && (k + 1 < int'(depth_q))) begin
                busy_w = 1'b1;
            end
        end
    end

    // D==1 bypasses the stages; otherwise the output register taps s(D-1).
    always_comb begin : out_source
        src_vld  = accept;
        src_data = in_term;
        for (int k = 0; k < NSTG; k++) begin
            if (int'(depth_q) == k + 2) begin
                src_vld  = stg_vld_q[k];
                src_data = stg_data_q[k];
            end
        end
    end

    always_comb begin : next_state
        stg_vld_d   = stg_vld_q;
        stg_data_d  = stg_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        depth_d     = depth_q;
        err_d       = err_q;

        if (flush) begin
            stg_vld_d = '0;
            for (int k = 0; k < NSTG; k++) begin
                stg_data_d[k] = '0;
            end
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (advance) begin
            // Stages past D-1 are zeroed so a later depth increase cannot
            // resurrect a beat that already left through the output.
            stg_vld_d[0]  = accept && (int'(depth_q) > 1);
            stg_data_d[0] = (int'(depth_q) > 1) ? in_term : '0;
            for (int k = 1; k < NSTG; k++) begin
                if (k + 1 < int'(depth_q)) begin
                    stg_vld_d[k]  = stg_vld_q[k-1];
                    stg_data_d[k] = stg_data_q[k-1];
                end else begin
                    stg_vld_d[k]  = 1'b0;
                    stg_data_d[k] = '0;
                end
            end
            out_valid_d = src_vld;
            out_data_d  = src_data;
        end

        if (flush || !busy_w) begin
            depth_d = depth_req;
            err_d   = err_q | depth_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                stg_data_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            depth_q     <= SEL_W'(DEF_DEPTH);
            err_q       <= 1'b0;
        end else begin
            stg_vld_q   <= stg_vld_d;
            stg_data_q  <= stg_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_w;
    assign active_depth  = depth_q;
    assign depth_err     = err_q;
endmodule

// File: tb/tb_param_delay.sv
// tb/tb_param_delay.sv - scoreboard-based bench for param_delay
module tb_param_delay;
    localparam int DATA_W    = 32;
    localparam int MAX_DEPTH = 16;
    localparam int DEF_DEPTH = 7;
    localparam int SEL_W     = $clog2(MAX_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush;
    logic [SEL_W-1:0] depth_sel;
    logic             busy;
    logic [SEL_W-1:0] active_depth;
    logic             depth_err;

    param_delay_if #(.DATA_W(DATA_W)) bus ();

    param_delay #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH),
        .DEF_DEPTH(DEF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall       (stall),
        .flush       (flush),
        .depth_sel   (depth_sel),
        .busy        (busy),
        .active_depth(active_depth),
        .depth_err   (depth_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                tag;
    } exp_t;

    exp_t q[$];
    int   adv      = 0;
    int   depth_m  = DEF_DEPTH;
    bit   err_m    = 1'b0;
    bit   mon_en   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a beat is tagged with the advance count at which it must be on the output.
    always @(posedge clk) begin
        bit busy_m;
        bit bad;
        int req;
        busy_m = (q.size() != 0);
        req    = int'(depth_sel);
        bad    = 1'b0;
        if (req == 0) begin
            req = 1;
            bad = 1'b1;
        end else if (req > MAX_DEPTH) begin
            req = MAX_DEPTH;
            bad = 1'b1;
        end
        if (rst) begin
            q.delete();
            depth_m = DEF_DEPTH;
            err_m   = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else if (!stall) begin
                if (q.size() != 0 && q[0].tag == adv) void'(q.pop_front());
                adv++;
                if (bus.in_valid) q.push_back('{bus.in_data, adv + depth_m - 1});
            end
            if (flush || !busy_m) begin
                depth_m = req;
                err_m   = err_m | bad;
            end
        end
    end

    always @(negedge clk) begin
        bit                ev;
        logic [DATA_W-1:0] ed;
        if (mon_en) begin
            ev = (q.size() != 0 && q[0].tag == adv);
            ed = ev ? q[0].data : '0;
            checks++;
            if (bus.out_valid !== ev) begin
                failures++;
                $display("FAIL sb_out_valid t=%0t got=%0b exp=%0b", $time, bus.out_valid, ev);
            end
            checks++;
            if (bus.out_data !== ed) begin
                failures++;
                $display("FAIL sb_out_data t=%0t got=%h exp=%h", $time, bus.out_data, ed);
            end
            checks++;
            if (busy !== (q.size() != 0)) begin
                failures++;
                $display("FAIL sb_busy t=%0t got=%0b exp=%0b", $time, busy, q.size() != 0);
            end
            checks++;
            if (active_depth !== SEL_W'(depth_m)) begin
                failures++;
                $display("FAIL sb_active_depth t=%0t got=%0d exp=%0d", $time, active_depth, depth_m);
            end
            checks++;
            if (depth_err !== err_m) begin
                failures++;
                $display("FAIL sb_depth_err t=%0t got=%0b exp=%0b", $time, depth_err, err_m);
            end
            checks++;
            if (bus.in_ready !== ~stall) begin
                failures++;
                $display("FAIL sb_in_ready t=%0t got=%0b exp=%0b", $time, bus.in_ready, ~stall);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        stall        = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        depth_sel = SEL_W'(DEF_DEPTH);
        drive_idle();
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || busy !== 1'b0 ||
            active_depth !== SEL_W'(7) || depth_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ov=%0b od=%h busy=%0b ad=%0d err=%0b exp ov=0 od=0 busy=0 ad=7 err=0",
                     bus.out_valid, bus.out_data, busy, active_depth, depth_err);
        end
        rst = 1'b0;
        tick();
        for (int c = 0; c <= 10; c++) begin
            bus.in_valid = (c == 0);
            bus.in_data  = (c == 0) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (bus.out_valid !== (c == 7) || bus.out_data !== ((c == 7) ? 32'hDEADBEEF : 32'h0)) begin
                    failures++;
                    $display("FAIL reset_default_latency cycle=%0d got=%0b/%h exp=%0b/%h", c,
                             bus.out_valid, bus.out_data, c == 7, (c == 7) ? 32'hDEADBEEF : 32'h0);
                end
            end
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0BAD0001;
        tick();
        tick();
        rst   = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_override ov=%0b busy=%0b exp 0/0", bus.out_valid, busy);
        end
        rst = 1'b0;
        drive_idle();
        for (int c = 0; c < 9; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_lost_beat cycle=%0d got=%0b exp=0", c, bus.out_valid);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        depth_sel = SEL_W'(3);
        tick();
        @(negedge clk);
        checks++;
        if (active_depth !== SEL_W'(3)) begin
            failures++;
            $display("FAIL b2b_depth got=%0d exp=3", active_depth);
        end
        tick();
        for (int c = 0; c <= 24; c++) begin
            bus.in_valid = (c < 20);
            bus.in_data  = (c < 20) ? 32'(c + 1) : 32'h0;
            @(negedge clk);
            if (c >= 3 && c <= 22) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(c - 2)) begin
                    failures++;
                    $display("FAIL b2b_out cycle=%0d got=%0b/%0d exp=1/%0d", c, bus.out_valid, bus.out_data, c - 2);
                end
            end
            if (c == 22 || c == 23) begin
                checks++;
                if (busy !== (c == 22)) begin
                    failures++;
                    $display("FAIL b2b_busy cycle=%0d got=%0b exp=%0b", c, busy, c == 22);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        depth_sel = SEL_W'(4);
        tick();
        tick();
        for (int c = 0; c <= 14; c++) begin
            bus.in_valid = (c == 0) || (c >= 2 && c <= 6);
            bus.in_data  = (c == 0) ? 32'hA5A50001 : 32'h55550000 + 32'(c);
            stall        = (c >= 2 && c <= 6) || (c >= 9 && c <= 11);
            @(negedge clk);
            if (stall) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready cycle=%0d got=%0b exp=0", c, bus.in_ready);
                end
            end
            checks++;
            if (bus.out_valid !== (c >= 9 && c <= 12) ||
                bus.out_data !== ((c >= 9 && c <= 12) ? 32'hA5A50001 : 32'h0)) begin
                failures++;
                $display("FAIL stall_out cycle=%0d got=%0b/%h exp=%0b/%h", c, bus.out_valid, bus.out_data,
                         c >= 9 && c <= 12, (c >= 9 && c <= 12) ? 32'hA5A50001 : 32'h0);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_depth_change();
        depth_sel = SEL_W'(7);
        tick();
        tick();
        for (int c = 0; c <= 13; c++) begin
            bus.in_valid = (c == 0) || (c == 10);
            bus.in_data  = (c == 0) ? 32'h00007777 : 32'h00002222;
            depth_sel    = (c == 0) ? SEL_W'(7) : SEL_W'(2);
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (active_depth !== ((c <= 8) ? SEL_W'(7) : SEL_W'(2))) begin
                    failures++;
                    $display("FAIL dchg_active cycle=%0d got=%0d exp=%0d", c, active_depth, (c <= 8) ? 7 : 2);
                end
            end
            if (c == 7 || c == 11 || c == 12) begin
                checks++;
                if (bus.out_valid !== (c != 11) ||
                    bus.out_data !== ((c == 7) ? 32'h7777 : (c == 12) ? 32'h2222 : 32'h0)) begin
                    failures++;
                    $display("FAIL dchg_out cycle=%0d got=%0b/%h", c, bus.out_valid, bus.out_data);
                end
            end
            if (c == 8) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL dchg_busy cycle=%0d got=%0b exp=0", c, busy);
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_flush();
        depth_sel = SEL_W'(3);
        tick();
        tick();
        for (int c = 0; c <= 14; c++) begin
            bus.in_valid = (c <= 4);
            bus.in_data  = 32'hF000 + 32'(c);
            depth_sel    = (c == 0) ? SEL_W'(3) : SEL_W'(6);
            flush        = (c == 4);
            stall        = (c == 4);
            @(negedge clk);
            if (c == 3 || c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hF000 + 32'(c - 3) || active_depth !== SEL_W'(3)) begin
                    failures++;
                    $display("FAIL flush_pre cycle=%0d got=%0b/%h ad=%0d exp=1/%h ad=3", c, bus.out_valid,
                             bus.out_data, active_depth, 32'hF000 + 32'(c - 3));
                end
            end
            if (c == 5) begin
                checks++;
                if (busy !== 1'b0 || active_depth !== SEL_W'(6)) begin
                    failures++;
                    $display("FAIL flush_post busy=%0b ad=%0d exp busy=0 ad=6", busy, active_depth);
                end
            end
            if (c >= 5) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_leak cycle=%0d got=%0b exp=0", c, bus.out_valid);
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_illegal_depth();
        depth_sel = '0;
        tick();
        @(negedge clk);
        checks++;
        if (active_depth !== SEL_W'(1) || depth_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_zero ad=%0d err=%0b exp ad=1 err=1", active_depth, depth_err);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00001111;
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1111) begin
            failures++;
            $display("FAIL illegal_d1_out got=%0b/%h exp=1/00001111", bus.out_valid, bus.out_data);
        end
        depth_sel = SEL_W'(3);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (active_depth !== SEL_W'(3) || depth_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_sticky ad=%0d err=%0b exp ad=3 err=1", active_depth, depth_err);
        end
        depth_sel = SEL_W'(31);
        tick();
        @(negedge clk);
        checks++;
        if (active_depth !== SEL_W'(16) || depth_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_high ad=%0d err=%0b exp ad=16 err=1", active_depth, depth_err);
        end
        tick();
        for (int c = 0; c <= 17; c++) begin
            bus.in_valid = (c == 0);
            bus.in_data  = 32'h16161616;
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (bus.out_valid !== (c == 16)) begin
                    failures++;
                    $display("FAIL max_depth_latency cycle=%0d got=%0b exp=%0b", c, bus.out_valid, c == 16);
                end
            end
            tick();
        end
        drive_idle();
        depth_sel = SEL_W'(DEF_DEPTH);
        rst       = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (depth_err !== 1'b0 || active_depth !== SEL_W'(7)) begin
            failures++;
            $display("FAIL illegal_reset_clear err=%0b ad=%0d exp err=0 ad=7", depth_err, active_depth);
        end
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        depth_sel    = SEL_W'(DEF_DEPTH);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_depth_change();
        test_flush();
        test_illegal_depth();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
